// File: rtl/row_sum_scheduler.sv
// Row-summation scheduler: round-robin arbitration over PE requesters,
// three-lane accumulation across ROWS packets, threshold spikes, one result out.
module row_sum_scheduler #(
    parameter int         NUM_PE  = 4,
    parameter int         ROWS    = 3,
    parameter logic [9:0] THRESH  = 10'd24,
    parameter logic [3:0] OUT_SRC = 4'h0,
    parameter logic [3:0] OUT_DST = 4'h1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PE-1:0]      in_valid,
    input  logic [39*NUM_PE-1:0]   in_data,
    output logic [NUM_PE-1:0]      in_ready,
    output logic                   out_valid,
    output logic [38:0]            out_data,
    input  logic                   out_ready,
    output logic [7:0]             drop_cnt
);

    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {ACCUM, COMPUTE, EMIT} state_t;

    state_t        r_state;
    logic [PW-1:0] r_rr_ptr;
    logic [9:0]    r_acc1, r_acc2, r_acc3;
    logic [3:0]    r_cnt;
    logic          r_out_valid;
    logic [38:0]   r_out_data;
    logic [7:0]    r_drop_cnt;

    logic          w_found;
    logic [PW-1:0] w_gnt;
    logic [PW-1:0] w_cand;
    logic [PW-1:0] w_next_ptr;
    logic [38:0]   w_pkt;
    logic          w_xfer;
    logic          w_is_psum;
    logic [8:0]    w_l1, w_l2, w_l3;

    function automatic logic [9:0] sat_add(input logic [9:0] a,
                                           input logic [7:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {3'b000, b};
        return s[10] ? 10'h3FF : s[9:0];
    endfunction

    // Returns {spike, 8-bit lane value}.
    function automatic logic [8:0] lane_out(input logic [9:0] acc);
        logic       sp;
        logic [9:0] d;
        sp = (acc >= THRESH);
        d  = sp ? (acc - THRESH) : acc;
        return {sp, (d > 10'd255) ? 8'hFF : d[7:0]};
    endfunction

    // Search starts at the round-robin pointer and wraps.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            w_cand = PW'((int'(r_rr_ptr) + k) % NUM_PE);
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_xfer     = (r_state == ACCUM) && w_found && !reset;
    assign in_ready   = w_xfer ? (NUM_PE'(1) << w_gnt) : '0;
    assign w_pkt      = in_data[39*int'(w_gnt) +: 39];
    assign w_is_psum  = (w_pkt[38:37] == 2'b01);
    assign w_next_ptr = (int'(w_gnt) == NUM_PE - 1) ? '0 : w_gnt + PW'(1);

    assign w_l1 = lane_out(r_acc1);
    assign w_l2 = lane_out(r_acc2);
    assign w_l3 = lane_out(r_acc3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ACCUM;
            r_rr_ptr    <= '0;
            r_acc1      <= '0;
            r_acc2      <= '0;
            r_acc3      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_xfer) begin
                        r_rr_ptr <= w_next_ptr;
                        if (w_is_psum) begin
                            r_acc1 <= sat_add(r_acc1, w_pkt[23:16]);
                            r_acc2 <= sat_add(r_acc2, w_pkt[15:8]);
                            r_acc3 <= sat_add(r_acc3, w_pkt[7:0]);
                            r_cnt  <= r_cnt + 4'd1;
                            if (r_cnt + 4'd1 == 4'(ROWS))
                                r_state <= COMPUTE;
                        end else if (r_drop_cnt != 8'hFF) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                    end
                end
                COMPUTE: begin
                    r_out_data  <= {2'b10, OUT_SRC, OUT_DST, 2'b00,
                                    w_l1[8], w_l2[8], w_l3[8],
                                    w_l1[7:0], w_l2[7:0], w_l3[7:0]};
                    r_out_valid <= 1'b1;
                    r_acc1      <= '0;
                    r_acc2      <= '0;
                    r_acc3      <= '0;
                    r_cnt       <= '0;
                    r_state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_row_sum_scheduler.sv
// Directed bench for row_sum_scheduler: default instance plus a
// ROWS=8 instance for accumulator saturation.
module tb_row_sum_scheduler;

    logic         clk;
    logic         reset;
    logic [3:0]   in_valid;
    logic [155:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [38:0]  out_data;
    logic         out_ready;
    logic [7:0]   drop_cnt;

    logic [1:0]   s_valid;
    logic [77:0]  s_data;
    logic [1:0]   s_ready;
    logic         s_out_valid;
    logic [38:0]  s_out_data;
    logic         s_out_ready;
    logic [7:0]   s_drop;

    int tests = 0;
    int fails = 0;

    row_sum_scheduler u0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    row_sum_scheduler #(.NUM_PE(2), .ROWS(8)) u1 (
        .clk(clk), .reset(reset),
        .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
        .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(s_out_ready), .drop_cnt(s_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [38:0] pk(input logic [1:0] t,
                                       input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c);
        return {t, 4'h2, 4'h0, 5'h00, a, b, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Offer one packet from requester r alone and wait for its grant.
    task automatic push(input int r, input logic [38:0] p);
        logic got;
        got = 1'b0;
        in_valid = 4'b0001 << r;
        in_data[39*r +: 39] = p;
        for (int i = 0; i < 16 && !got; i++) begin
            smp();
            if (in_ready[r]) got = 1'b1;
            nx();
        end
        in_valid = 4'b0000;
        check("push_grant", {63'd0, got}, 64'd1);
    endtask

    // Called in the cycle after the last accept; out_ready must be 1.
    task automatic expect_result(input string tag, input logic [38:0] exp);
        smp();
        check({tag, "_compute_valid"}, {63'd0, out_valid}, 64'd0);
        nx();
        smp();
        check({tag, "_emit_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_data"}, {25'd0, out_data}, {25'd0, exp});
        nx();
        smp();
        check({tag, "_accepted"}, {63'd0, out_valid}, 64'd0);
        nx();
    endtask

    logic [38:0] pA, pB, pC, p111, pBad, pBig, pS;
    logic [38:0] R1, R3, RS;
    logic [3:0]  eg;
    int          exp_g;

    initial begin
        pA   = pk(2'b01, 8'd14, 8'd5, 8'd8);
        pB   = pk(2'b01, 8'd4, 8'd8, 8'd7);
        pC   = pk(2'b01, 8'd10, 8'd9, 8'd10);
        p111 = pk(2'b01, 8'd1, 8'd1, 8'd1);
        pBad = pk(2'b11, 8'd200, 8'd200, 8'd200);
        pBig = pk(2'b01, 8'd50, 8'd50, 8'd50);
        pS   = pk(2'b01, 8'd255, 8'd255, 8'd0);
        R1   = {2'b10, 4'h0, 4'h1, 2'b00, 3'b101, 8'd4, 8'd22, 8'd1};
        R3   = {2'b10, 4'h0, 4'h1, 2'b00, 3'b000, 8'd3, 8'd3, 8'd3};
        RS   = {2'b10, 4'h0, 4'h1, 2'b00, 3'b110, 8'hFF, 8'hFF, 8'h00};

        reset       = 1'b1;
        in_valid    = 4'hF;
        in_data     = '0;
        out_ready   = 1'b0;
        s_valid     = 2'b00;
        s_data      = '0;
        s_out_ready = 1'b1;

        // Reset values
        nx();
        nx();
        smp();
        check("rst_in_ready", {60'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {25'd0, out_data}, 64'd0);
        check("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
        nx();
        reset    = 1'b0;
        in_valid = 4'h0;

        // Single requester with spiking lanes, then backpressure
        push(0, pA);
        push(0, pB);
        push(0, pC);
        smp();
        check("lat_compute_valid", {63'd0, out_valid}, 64'd0);
        nx();
        smp();
        check("lat_emit_valid", {63'd0, out_valid}, 64'd1);
        check("single_data", {25'd0, out_data}, {25'd0, R1});
        nx();
        in_valid = 4'hF;
        in_data  = {p111, p111, p111, p111};
        for (int i = 0; i < 10; i++) begin
            smp();
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data", {25'd0, out_data}, {25'd0, R1});
            check("bp_in_ready", {60'd0, in_ready}, 64'd0);
            nx();
        end
        out_ready = 1'b1;
        smp();
        check("bp_last_valid", {63'd0, out_valid}, 64'd1);
        nx();

        // Round-robin with all requesters valid; pointer is 1 here
        exp_g = 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                smp();
                eg = 4'b0001 << exp_g;
                check("rr_grant", {60'd0, in_ready}, {60'd0, eg});
                exp_g = (exp_g + 1) % 4;
                nx();
            end
            smp();
            check("rr_compute_ready", {60'd0, in_ready}, 64'd0);
            check("rr_compute_valid", {63'd0, out_valid}, 64'd0);
            nx();
            smp();
            check("rr_emit_valid", {63'd0, out_valid}, 64'd1);
            check("rr_data", {25'd0, out_data}, {25'd0, R3});
            check("rr_emit_ready", {60'd0, in_ready}, 64'd0);
            nx();
        end
        in_valid = 4'h0;

        // Discarded packet between valid ones
        push(0, pA);
        push(2, pBad);
        push(0, pB);
        push(0, pC);
        expect_result("drop_res", R1);
        smp();
        check("drop_cnt_1", {56'd0, drop_cnt}, 64'd1);
        nx();

        // drop_cnt saturation: 260 bad packets in total
        in_valid = 4'b0010;
        in_data[77:39] = pBad;
        for (int i = 0; i < 253; i++) nx();
        smp();
        check("drop_cnt_254", {56'd0, drop_cnt}, 64'd254);
        nx();
        for (int i = 0; i < 6; i++) nx();
        smp();
        check("drop_cnt_sat", {56'd0, drop_cnt}, 64'd255);
        check("drop_no_result", {63'd0, out_valid}, 64'd0);
        nx();
        in_valid = 4'h0;

        // Reset after 2 of 3 packets
        push(0, pBig);
        push(1, pBig);
        reset = 1'b1;
        nx();
        smp();
        check("mid_rst_drop", {56'd0, drop_cnt}, 64'd0);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        nx();
        reset    = 1'b0;
        in_valid = 4'hF;
        in_data  = {pBig, pC, pB, pA};
        for (int k = 0; k < 3; k++) begin
            smp();
            eg = 4'b0001 << k;
            check("mid_rst_grant", {60'd0, in_ready}, {60'd0, eg});
            nx();
        end
        in_valid = 4'h0;
        expect_result("mid_rst_res", R1);

        // ROWS=8 saturation on the second instance
        s_valid = 2'b01;
        s_data[38:0] = pS;
        for (int k = 0; k < 8; k++) begin
            smp();
            check("sat_grant", {62'd0, s_ready}, 64'd1);
            nx();
        end
        s_valid = 2'b00;
        smp();
        check("sat_compute_valid", {63'd0, s_out_valid}, 64'd0);
        nx();
        smp();
        check("sat_emit_valid", {63'd0, s_out_valid}, 64'd1);
        check("sat_data", {25'd0, s_out_data}, {25'd0, RS});
        nx();
        smp();
        check("sat_accepted", {63'd0, s_out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
